// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: ops, controller size codes, FSM states.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } op_e;

  localparam logic [3:0]  SIZE_WORD = 4'd0;
  localparam logic [3:0]  SIZE_HALF = 4'd2;
  localparam logic [3:0]  SIZE_BYTE = 4'd3;
  localparam logic [31:0] ZERO      = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_store(input op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Loads report SIZE_WORD; the controller ignores the size on reads.
  function automatic logic [3:0] size_code(input op_e op);
    logic [3:0] sz;
    case (op)
      OP_SB:   sz = SIZE_BYTE;
      OP_SH:   sz = SIZE_HALF;
      default: sz = SIZE_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_ext.sv
// Load-data extension: picks the low byte/half/word of the raw little-endian word and extends it.
module lsu_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o
);

  always_comb begin
    ext_o = raw_i;
    case (op_e'(op_i))
      OP_LB:   ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
      OP_LBU:  ext_o = {24'd0, raw_i[7:0]};
      OP_LH:   ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
      OP_LHU:  ext_o = {16'd0, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: one transaction per accept on the memory controller data port.
//   state | meaning
//   IDLE  | waiting for valid_i; latches op/address/data/size on accept
//   BUSY  | request to controller held until ram_done_i
//   RESP  | one-cycle done_o pulse with registered rdata_o
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        ram_r_req,
  output logic        ram_w_req,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_size_o,
  output logic [31:0] ram_w_data_o,
  input  logic [31:0] ram_r_data_i,
  input  logic        ram_done_i
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  size_q, size_d;
  logic [31:0] ext_data;

  lsu_ext u_ext (
    .op_i  (op_q),
    .raw_i (ram_r_data_i),
    .ext_o (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LB;
      addr_q  <= ZERO;
      wdata_q <= ZERO;
      rdata_q <= ZERO;
      size_q  <= SIZE_WORD;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          op_d    = op_e'(op_i);
          addr_d  = addr_i;
          wdata_d = wdata_i;
          size_d  = size_code(op_e'(op_i));
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (ram_done_i) begin
          rdata_d = is_store(op_q) ? ZERO : ext_data;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Requests drop in the ram_done_i cycle so the controller does not restart at that edge.
  always_comb begin
    stall_o   = (valid_i && (state_q == ST_IDLE)) || (state_q == ST_BUSY);
    ram_w_req = (state_q == ST_BUSY) && is_store(op_q) && !ram_done_i;
    ram_r_req = (state_q == ST_BUSY) && !is_store(op_q) && !ram_done_i;
    done_o    = (state_q == ST_RESP);
  end

  assign rdata_o      = rdata_q;
  assign ram_addr_o   = addr_q;
  assign ram_size_o   = size_q;
  assign ram_w_data_o = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: byte-addressed controller model with random latency plus a reference memory.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [2:0]  op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        ram_r_req;
  logic        ram_w_req;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_size_o;
  logic [31:0] ram_w_data_o;
  logic [31:0] ram_r_data_i = 32'd0;
  logic        ram_done_i = 1'b0;

  always #5 clk = ~clk;

  lsu dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .op_i         (op_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .ram_r_req    (ram_r_req),
    .ram_w_req    (ram_w_req),
    .ram_addr_o   (ram_addr_o),
    .ram_size_o   (ram_size_o),
    .ram_w_data_o (ram_w_data_o),
    .ram_r_data_i (ram_r_data_i),
    .ram_done_i   (ram_done_i)
  );

  bit [7:0] mem [bit [31:0]];
  bit [7:0] ref_mem [bit [31:0]];
  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int rd_count = 0;
  bit ctrl_busy = 0;
  int ctrl_cnt = 0;
  bit inject_done = 0;

  // Controller: samples requests when vacant, completes after a random delay,
  // and goes vacant again at the edge ending the ram_done_i cycle.
  always @(posedge clk) begin
    if (rst) begin
      ctrl_busy = 0;
      ram_done_i <= 1'b0;
    end else begin
      if (ctrl_busy && ram_done_i) ctrl_busy = 0;
      ram_done_i <= 1'b0;
      if (!ctrl_busy) begin
        if (ram_r_req || ram_w_req) begin
          ctrl_busy = 1;
          ctrl_cnt = $urandom_range(1, 4);
          if (ram_w_req) wr_count++;
          else rd_count++;
        end
      end else if (ctrl_cnt > 0) begin
        ctrl_cnt--;
        if (ctrl_cnt == 0) begin
          if (ram_w_req) begin
            int n;
            n = (ram_size_o == 4'd3) ? 1 : (ram_size_o == 4'd2) ? 2 : 4;
            for (int i = 0; i < n; i++) mem[ram_addr_o + i] = ram_w_data_o[8*i +: 8];
          end
          ram_r_data_i <= {mem_rd(ram_addr_o + 3), mem_rd(ram_addr_o + 2),
                           mem_rd(ram_addr_o + 1), mem_rd(ram_addr_o)};
          ram_done_i <= 1'b1;
        end
      end
      if (inject_done) ram_done_i <= 1'b1;
    end
  end

  function automatic bit [7:0] mem_rd(input bit [31:0] a);
    return mem.exists(a) ? mem[a] : 8'd0;
  endfunction

  function automatic bit [7:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit op_is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [31:0] exp_size(input logic [2:0] op);
    if (op == OP_SB) return 32'd3;
    if (op == OP_SH) return 32'd2;
    return 32'd0;
  endfunction

  // Load result from the reference memory, extended by plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    longint b0, lo16, word;
    b0   = ref_rd(a);
    lo16 = b0 + 256 * longint'(ref_rd(a + 1));
    word = lo16 + 65536 * (longint'(ref_rd(a + 2)) + 256 * longint'(ref_rd(a + 3)));
    case (op)
      OP_LB:   return (b0 > 127) ? 32'(b0 - 256) : 32'(b0);
      OP_LBU:  return 32'(b0);
      OP_LH:   return (lo16 > 32767) ? 32'(lo16 - 65536) : 32'(lo16);
      OP_LHU:  return 32'(lo16);
      OP_LW:   return 32'(word);
      default: return 32'd0;
    endcase
  endfunction

  // Starts at a negedge; returns at the negedge of the done_o cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input bit chained);
    logic [31:0] exp_rd;
    int wr0, rd0, nbytes;
    bit prev_done, got, is_st;
    is_st = op_is_store(op);
    exp_rd = ref_load(op, a);
    wr0 = wr_count;
    rd0 = rd_count;
    got = 0;
    prev_done = 0;
    valid_i = 1'b1;
    op_i = op;
    addr_i = a;
    wdata_i = wd;
    if (!chained) begin
      #1;
      chk("stall_accept", stall_o, 1);
    end
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (done_o) begin
        got = 1;
        chk("done_after_ram_done", prev_done, 1);
        chk("rdata", rdata_o, exp_rd);
        chk("stall_resp", stall_o, 0);
        chk("txn_count", (wr_count - wr0) + (rd_count - rd0), 1);
        chk("txn_kind_wr", wr_count - wr0, is_st);
        chk("addr_hold", ram_addr_o, a);
        if (is_st) begin
          nbytes = (op == OP_SB) ? 1 : (op == OP_SH) ? 2 : 4;
          for (int i = 0; i < nbytes; i++) ref_mem[a + i] = wd[8*i +: 8];
          for (int i = 0; i < 4; i++) chk("mem_byte", mem_rd(a + i), ref_rd(a + i));
        end
      end else begin
        chk("stall_busy", stall_o, 1);
        if (ram_r_req || ram_w_req) begin
          chk("req_addr", ram_addr_o, a);
          chk("req_size", ram_size_o, exp_size(op));
          if (is_st) chk("req_wdata", ram_w_data_o, wd);
          chk("req_is_read", ram_r_req, !is_st);
        end
        if (ram_done_i) chk("req_gated", {ram_r_req, ram_w_req}, 0);
      end
      prev_done = ram_done_i;
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic idle();
    valid_i = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done_o, 0);
  endtask

  logic [31:0] rd_keep;

  initial begin
    rst = 1'b1;
    valid_i = 1'b0;
    op_i = 3'd0;
    addr_i = 32'd0;
    wdata_i = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_stall", stall_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_addr", ram_addr_o, 0);
    chk("rst_size", ram_size_o, 0);
    chk("rst_wdata", ram_w_data_o, 0);
    chk("rst_req", {ram_r_req, ram_w_req}, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      mem[32'h1000 + i] = 8'(8'h11 * (i + 1));
      ref_mem[32'h1000 + i] = 8'(8'h11 * (i + 1));
    end
    mem[32'h1100] = 8'h80;  ref_mem[32'h1100] = 8'h80;
    mem[32'h1200] = 8'h01;  ref_mem[32'h1200] = 8'h01;
    mem[32'h1201] = 8'h80;  ref_mem[32'h1201] = 8'h80;

    @(negedge clk);
    run_op(OP_LW, 32'h1000, 32'd0, 0);
    chk("lw_known_value", rdata_o, 32'h44332211);
    idle();
    run_op(OP_LB, 32'h1100, 32'd0, 0);
    chk("lb_known_value", rdata_o, 32'hFFFFFF80);
    idle();
    run_op(OP_LBU, 32'h1100, 32'd0, 0);
    chk("lbu_known_value", rdata_o, 32'h00000080);
    idle();
    run_op(OP_LH, 32'h1200, 32'd0, 0);
    chk("lh_known_value", rdata_o, 32'hFFFF8001);
    idle();
    run_op(OP_LHU, 32'h1200, 32'd0, 0);
    chk("lhu_known_value", rdata_o, 32'h00008001);
    idle();
    run_op(OP_SH, 32'h2000, 32'h1234ABCD, 0);
    chk("sh_byte0", mem_rd(32'h2000), 32'hCD);
    chk("sh_byte1", mem_rd(32'h2001), 32'hAB);
    chk("sh_byte2", mem_rd(32'h2002), 32'h00);
    idle();
    run_op(OP_SB, 32'h30000, 32'h00000041, 0);
    chk("sb_io_byte", mem_rd(32'h30000), 32'h41);
    idle();

    rd_keep = rdata_o;
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    @(negedge clk);
    chk("stray_done_ignored", done_o, 0);
    chk("stray_rdata_kept", rdata_o, rd_keep);
    chk("stray_no_stall", stall_o, 0);

    run_op(OP_LW, 32'h1000, 32'd0, 0);
    run_op(OP_LH, 32'h1200, 32'd0, 1);
    idle();

    valid_i = 1'b1;
    op_i = OP_LW;
    addr_i = 32'h1000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    valid_i = 1'b0;
    @(negedge clk);
    chk("midrst_stall", stall_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_rdata", rdata_o, 0);
    chk("midrst_addr", ram_addr_o, 0);
    chk("midrst_req", {ram_r_req, ram_w_req}, 0);
    rst = 1'b0;
    @(negedge clk);
    run_op(OP_LW, 32'h1000, 32'd0, 0);
    chk("post_rst_lw", rdata_o, 32'h44332211);

    for (int k = 0; k < 40; k++) begin
      bit ch;
      logic [2:0] rop;
      ch = 1'($urandom_range(0, 1));
      rop = 3'($urandom_range(0, 7));
      if (!ch) idle();
      run_op(rop, 32'h1000 + 32'($urandom_range(0, 31)), $urandom, ch);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
